// File: rtl/num_scroll_ctrl_pkg.sv
// num_pkg: shared FSM states, row type and grid dimensions for the scroll sequencer.
package num_pkg;
    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 6;
    localparam int EDIT_COLS = 5;
    typedef enum logic [2:0] {IDLE, CHECK, SCROLL, SHIFT, FILL} state_t;
    typedef logic [NUM_COLS-1:0][3:0] row_t;
endpackage

// File: rtl/num_scroll_ctrl_if.sv
// num_scroll_ctrl_if: edit/submit/next-row handshake and display outputs of num_scroll_ctrl.
interface num_scroll_ctrl_if #(parameter int SCORE_W = 8);
    logic               i_frame_tick;
    logic               i_edit_valid;
    logic [2:0]         i_edit_pos;
    logic [3:0]         i_edit_digit;
    logic               i_submit;
    logic [19:0]        i_expected;
    logic [23:0]        i_next_row;
    logic               i_next_valid;
    logic               o_next_ready;
    logic [95:0]        o_digit_showed;
    logic [1:0]         o_correctness;
    logic [10:0]        o_displacement;
    logic               o_busy;
    logic [SCORE_W-1:0] o_score;
    modport master (
        output i_frame_tick, i_edit_valid, i_edit_pos, i_edit_digit, i_submit, i_expected, i_next_row, i_next_valid,
        input  o_next_ready, o_digit_showed, o_correctness, o_displacement, o_busy, o_score
    );
    modport slave (
        input  i_frame_tick, i_edit_valid, i_edit_pos, i_edit_digit, i_submit, i_expected, i_next_row, i_next_valid,
        output o_next_ready, o_digit_showed, o_correctness, o_displacement, o_busy, o_score
    );
endinterface

// File: rtl/num_scroll_ctrl_row_compare.sv
// num_row_compare: combinational equality of the five editable digits of a row against an answer.
module num_row_compare
    import num_pkg::*;
(
    input  logic [EDIT_COLS-1:0][3:0] digits_i,
    input  logic [19:0]               expected_i,
    output logic                      match_o
);
    always_comb match_o = digits_i == expected_i;
endmodule

// File: rtl/num_scroll_ctrl.sv
// num_scroll_ctrl: digit grid editor, scorer and one-row scroll sequencer feeding display_nums.
// NUM_SCROLL_ANIM_EN: defined = animated scroll in STEP pixel increments; undefined = instant jump on a frame tick.
module num_scroll_ctrl
    import num_pkg::*;
#(
    parameter int ROW_PITCH = 150,
    parameter int STEP      = 5,
    parameter int SCORE_W   = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    num_scroll_ctrl_if.slave  bus
);
`ifdef NUM_SCROLL_ANIM_EN
    localparam logic [10:0] TICK_PX = 11'(STEP);
`else
    // Instant jump: displacement never moves, the first tick alone ends the scroll.
    localparam logic [10:0] TICK_PX = 11'(STEP * 0);
`endif
    localparam logic [10:0] PITCH_PX = 11'(ROW_PITCH);

    state_t               state_q;
    row_t                 row_q [NUM_ROWS];
    logic [1:0]           corr_q;
    logic [10:0]          disp_q;
    logic [SCORE_W-1:0]   score_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 match;
    logic [10:0]          disp_nx;

    num_row_compare u_cmp (
        .digits_i   (row_q[1][NUM_COLS-1 -: EDIT_COLS]),
        .expected_i (bus.i_expected),
        .match_o    (match)
    );

    always_comb disp_nx = disp_q + TICK_PX;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            for (int r = 0; r < NUM_ROWS; r++) row_q[r] <= '0;
            corr_q  <= '0;
            disp_q  <= '0;
            score_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_submit) begin
                        state_q <= CHECK;
                        busy_q  <= 1'b1;
                    end else if (bus.i_edit_valid && bus.i_edit_pos < 3'(EDIT_COLS) && bus.i_edit_digit <= 4'd9) begin
                        row_q[1][3'(EDIT_COLS) - bus.i_edit_pos] <= bus.i_edit_digit;
                    end
                end
                CHECK: begin
                    corr_q[1] <= match;
                    if (match && !(&score_q)) score_q <= score_q + 1'b1;
                    state_q <= SCROLL;
                end
                SCROLL: begin
                    if (bus.i_frame_tick) begin
                        disp_q <= disp_nx;
                        if (disp_nx == PITCH_PX || TICK_PX == '0) state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    row_q[0] <= row_q[1];
                    row_q[1] <= row_q[2];
                    row_q[2] <= row_q[3];
                    row_q[3] <= '0;
                    corr_q   <= {1'b0, corr_q[1]};
                    disp_q   <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= FILL;
                end
                FILL: begin
                    if (bus.i_next_valid && ready_q) begin
                        row_q[3] <= bus.i_next_row;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_digit_showed = {row_q[0], row_q[1], row_q[2], row_q[3]};
    assign bus.o_correctness  = corr_q;
    assign bus.o_displacement = disp_q;
    assign bus.o_score        = score_q;
    assign bus.o_next_ready   = ready_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_num_scroll_ctrl.sv
// tb_num_scroll_ctrl: table-driven edits plus randomized rounds checked against a digit-array model.
module tb_num_scroll_ctrl;
    localparam int PITCH = 150;
    localparam int STEP  = 5;
    localparam int SW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    num_scroll_ctrl_if #(.SCORE_W(SW)) bus ();
    num_scroll_ctrl #(.ROW_PITCH(PITCH), .STEP(STEP), .SCORE_W(SW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        v;
        logic [2:0]  pos;
        logic [3:0]  dig;
        logic [19:0] exp_row1;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_grid [4][6];
    logic [1:0] m_corr;
    int         m_score;
    vec_t       tbl [10];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] m_bits();
        logic [95:0] b;
        for (int k = 0; k < 24; k++) b[95-4*k -: 4] = m_grid[k/6][k%6];
        return b;
    endfunction

    function automatic logic [19:0] m_row1();
        logic [19:0] r;
        for (int c = 0; c < 5; c++) r[19-4*c -: 4] = m_grid[1][c];
        return r;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 6; c++) m_grid[r][c] = 4'd0;
        m_corr  = 2'b00;
        m_score = 0;
    endtask

    task automatic check_all(input string nm, input logic busy, input logic ready, input int disp);
        chk({nm, "_grid"}, bus.o_digit_showed, m_bits());
        chk({nm, "_corr"}, 96'(bus.o_correctness), 96'(m_corr));
        chk({nm, "_disp"}, 96'(bus.o_displacement), 96'(disp));
        chk({nm, "_score"}, 96'(bus.o_score), 96'(m_score));
        chk({nm, "_busy"}, 96'(bus.o_busy), 96'(busy));
        chk({nm, "_ready"}, 96'(bus.o_next_ready), 96'(ready));
    endtask

    task automatic clear_inputs();
        bus.i_frame_tick = 0;
        bus.i_edit_valid = 0;
        bus.i_edit_pos   = '0;
        bus.i_edit_digit = '0;
        bus.i_submit     = 0;
        bus.i_expected   = '0;
        bus.i_next_row   = '0;
        bus.i_next_valid = 0;
    endtask

    task automatic edit(input int pos, input int dig);
        bus.i_edit_valid = 1;
        bus.i_edit_pos   = 3'(pos);
        bus.i_edit_digit = 4'(dig);
        bus.i_frame_tick = 1'($urandom_range(0, 1));
        step();
        bus.i_edit_valid = 0;
        bus.i_frame_tick = 0;
        if (pos <= 4 && dig <= 9) m_grid[1][pos] = 4'(dig);
    endtask

    task automatic noise_cycle();
        bus.i_submit     = 1;
        bus.i_edit_valid = 1;
        bus.i_edit_pos   = 3'($urandom_range(0, 4));
        bus.i_edit_digit = 4'($urandom_range(0, 9));
        step();
        bus.i_submit     = 0;
        bus.i_edit_valid = 0;
        chk("ignored_grid", bus.o_digit_showed, m_bits());
    endtask

    task automatic round(input bit want_match, input int fill_wait, input int n_edits, input bit noise, input logic [23:0] nrow);
        logic [19:0] exp;
        bit          hit;
        for (int i = 0; i < n_edits; i++) edit($urandom_range(0, 7), $urandom_range(0, 15));
        check_all("idle", 0, 0, 0);
        exp = m_row1();
        if (!want_match) exp[3:0] = exp[3:0] + 4'd1;
        bus.i_expected = exp;
        bus.i_submit   = 1;
        if (noise) begin
            bus.i_edit_valid = 1;
            bus.i_edit_pos   = 3'($urandom_range(0, 4));
            bus.i_edit_digit = 4'($urandom_range(0, 9));
        end
        step();
        bus.i_submit     = 0;
        bus.i_edit_valid = 0;
        check_all("submit", 1, 0, 0);
        step();
        hit = (m_row1() == exp);
        m_corr[1] = hit;
        if (hit && m_score < 255) m_score++;
        check_all("check", 1, 0, 0);
`ifdef NUM_SCROLL_ANIM_EN
        for (int t = 1; t <= PITCH / STEP; t++) begin
            repeat ($urandom_range(0, 2)) begin
                if (noise) noise_cycle();
                else step();
            end
            bus.i_frame_tick = 1;
            step();
            bus.i_frame_tick = 0;
            chk("scroll_disp", 96'(bus.o_displacement), 96'(t * STEP));
        end
`else
        repeat (3) begin
            if (noise) noise_cycle();
            else step();
            check_all("wait_tick", 1, 0, 0);
        end
        bus.i_frame_tick = 1;
        step();
        bus.i_frame_tick = 0;
        check_all("after_tick", 1, 0, 0);
`endif
        step();
        for (int c = 0; c < 6; c++) begin
            m_grid[0][c] = m_grid[1][c];
            m_grid[1][c] = m_grid[2][c];
            m_grid[2][c] = m_grid[3][c];
            m_grid[3][c] = 4'd0;
        end
        m_corr = {1'b0, m_corr[1]};
        check_all("shift", 1, 1, 0);
        for (int i = 0; i < fill_wait; i++) begin
            bus.i_frame_tick = 1'($urandom_range(0, 1));
            step();
            chk("stall_ready", 96'(bus.o_next_ready), 96'(1));
            chk("stall_busy", 96'(bus.o_busy), 96'(1));
            chk("stall_disp", 96'(bus.o_displacement), 96'(0));
        end
        bus.i_frame_tick = 0;
        bus.i_next_row   = nrow;
        bus.i_next_valid = 1;
        step();
        bus.i_next_valid = 0;
        for (int c = 0; c < 6; c++) m_grid[3][c] = nrow[23-4*c -: 4];
        check_all("fill", 0, 0, 0);
    endtask

    initial begin
        clear_inputs();
        m_clear();
        step();
        check_all("reset", 0, 0, 0);
        rst_n = 1;
        step();
        check_all("post_reset", 0, 0, 0);

        tbl[0] = '{1, 3'd0, 4'd1,  20'h10000};
        tbl[1] = '{1, 3'd1, 4'd2,  20'h12000};
        tbl[2] = '{1, 3'd2, 4'd3,  20'h12300};
        tbl[3] = '{1, 3'd3, 4'd4,  20'h12340};
        tbl[4] = '{1, 3'd4, 4'd5,  20'h12345};
        tbl[5] = '{1, 3'd5, 4'd9,  20'h12345};
        tbl[6] = '{1, 3'd2, 4'd10, 20'h12345};
        tbl[7] = '{0, 3'd0, 4'd7,  20'h12345};
        tbl[8] = '{1, 3'd7, 4'd0,  20'h12345};
        tbl[9] = '{1, 3'd1, 4'd15, 20'h12345};
        for (int i = 0; i < 10; i++) begin
            bus.i_edit_valid = tbl[i].v;
            bus.i_edit_pos   = tbl[i].pos;
            bus.i_edit_digit = tbl[i].dig;
            step();
            bus.i_edit_valid = 0;
            if (tbl[i].v && tbl[i].pos <= 4 && tbl[i].dig <= 9) m_grid[1][tbl[i].pos] = tbl[i].dig;
            chk("tbl_row1", 96'(bus.o_digit_showed[71:52]), 96'(tbl[i].exp_row1));
            chk("tbl_hidden", 96'(bus.o_digit_showed[51:48]), 96'(0));
            chk("tbl_busy", 96'(bus.o_busy), 96'(0));
        end

        round(1, 2, 0, 0, 24'h987654);
        chk("row0_12345", 96'(bus.o_digit_showed[95:76]), 96'(20'h12345));
        chk("corr_01", 96'(bus.o_correctness), 96'(2'b01));
        chk("score_1", 96'(bus.o_score), 96'(1));

        for (int c = 0; c < 5; c++) edit(c, c + 1);
        round(0, 50, 0, 1, 24'hABCDEF);
        chk("row3_abcdef", 96'(bus.o_digit_showed[23:0]), 96'(24'hABCDEF));
        chk("mismatch_corr", 96'(bus.o_correctness), 96'(2'b00));
        chk("mismatch_score", 96'(bus.o_score), 96'(1));

        for (int r = 0; r < 20; r++)
            round(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6), 1, 24'($urandom));
        for (int r = 0; r < 260; r++) round(1, 0, 0, 0, 24'($urandom));
        chk("score_sat", 96'(bus.o_score), 96'(255));

        for (int c = 0; c < 5; c++) edit(c, 9 - c);
        bus.i_expected = 20'h98765;
        bus.i_submit   = 1;
        step();
        bus.i_submit = 0;
        step();
`ifdef NUM_SCROLL_ANIM_EN
        for (int t = 0; t < 15; t++) begin
            bus.i_frame_tick = 1;
            step();
        end
        bus.i_frame_tick = 0;
        chk("pre_reset_disp", 96'(bus.o_displacement), 96'(75));
`else
        step();
`endif
        #2 rst_n = 0;
        #1;
        m_clear();
        check_all("async_reset", 0, 0, 0);
        step();
        rst_n = 1;
        step();
        check_all("after_reset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
